// File: rtl/sram_1r1w_pipelined.sv
// Single-clock 1R1W tile memory with byte write mask, pipelined read latency,
// same-address write bypass and a post-reset clear sequencer.
module sram_1r1w_pipelined #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned DEPTH          = 64,
   parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
   parameter int unsigned READ_LATENCY   = 1,
   parameter bit          WR_BYPASS      = 1'b1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    w_csb,
   input  logic [ADDR_WIDTH-1:0]   w_addr,
   input  logic [DATA_WIDTH-1:0]   w_din,
   input  logic [DATA_WIDTH/8-1:0] w_mask,
   input  logic                    r_csb,
   input  logic [ADDR_WIDTH-1:0]   r_addr,
   output logic [DATA_WIDTH-1:0]   r_dout,
   output logic                    r_valid,
   output logic                    r_collision,
   output logic                    busy
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int Lat = int'(READ_LATENCY);
   localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [0:0] {StClear, StReady} state_e;

   state_e                  state_q;
   logic                    busy_q;
   logic [ADDR_WIDTH-1:0]   clr_ptr_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic [Lat-1:0]          pv_q;
   logic [Lat-1:0]          pc_q;
   logic [DATA_WIDTH-1:0]   pd_q [Lat];

   logic                    w_in_range;
   logic                    r_in_range;
   logic                    wr_en;
   logic                    rd_en;
   logic                    collide;
   logic [DATA_WIDTH-1:0]   rd_old;
   logic [DATA_WIDTH-1:0]   wr_merged;
   logic [DATA_WIDTH-1:0]   rd_data;

   always_comb begin
      w_in_range = {1'b0, w_addr} < DepthExt;
      r_in_range = {1'b0, r_addr} < DepthExt;
      wr_en      = (state_q == StReady) && !w_csb && w_in_range && !rst;
      rd_en      = (state_q == StReady) && !r_csb && !rst;
      collide    = wr_en && rd_en && (w_addr == r_addr);
      // Out-of-range reads return zero rather than an undefined array element
      rd_old     = r_in_range ? mem_q[r_addr] : '0;
      wr_merged  = rd_old;
      for (int b = 0; b < int'(NumBytes); b++) begin
         if (w_mask[b]) wr_merged[8*b +: 8] = w_din[8*b +: 8];
      end
      rd_data    = (collide && WR_BYPASS) ? wr_merged : rd_old;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR_ON_RESET ? StClear : StReady;
         busy_q    <= CLEAR_ON_RESET;
         clr_ptr_q <= '0;
      end else if (state_q == StClear) begin
         clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
         if (clr_ptr_q == LastAddr) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == StClear) begin
            mem_q[clr_ptr_q] <= '0;
         end else if (wr_en) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
               if (w_mask[b]) mem_q[w_addr][8*b +: 8] <= w_din[8*b +: 8];
            end
         end
      end
   end

   // Last stage only loads on a valid read so r_dout holds between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         pv_q <= '0;
         pc_q <= '0;
         for (int i = 0; i < Lat; i++) pd_q[i] <= '0;
      end else begin
         pv_q[0] <= rd_en;
         pc_q[0] <= collide;
         if (Lat > 1 || rd_en) pd_q[0] <= rd_data;
         for (int i = 1; i < Lat; i++) begin
            pv_q[i] <= pv_q[i-1];
            pc_q[i] <= pc_q[i-1];
            if (i < Lat - 1 || pv_q[i-1]) pd_q[i] <= pd_q[i-1];
         end
      end
   end

   always_comb begin
      r_dout      = pd_q[Lat-1];
      r_valid     = pv_q[Lat-1];
      r_collision = pc_q[Lat-1];
      busy        = busy_q;
   end

endmodule
